seg_scan_mux: RTL and testbench



---
 rtl/seg_scan_mux_pkg.sv | 15 +
 rtl/scan_prescaler.sv | 44 ++++
 rtl/seg_scan_mux.sv | 135 +++++++++++++
 tb/tb_seg_scan_mux.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_mux_pkg.sv
// Shared constants and helpers for the 7-segment digit scanner.
// Common-anode display: an anode bit is enabled by driving it low.
package seg_scan_mux_pkg;

    localparam int NDIG_DEFAULT = 4;
    localparam int DIV_DEFAULT  = 50000;

    // All anodes off; callers slice the low NDIG bits.
    localparam logic [31:0] AN_IDLE = 32'hFFFF_FFFF;

    function automatic int cnt_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Free-running divider producing a one-cycle tick every DIV clocks.
// The tick is registered by looking one count ahead.
module scan_prescaler
    import seg_scan_mux_pkg::*;
#(
    parameter int DIV = DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CNT_W = cnt_width(DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic             tick_r;

    // Next prescaler count with wrap at DIV-1.
    always_comb begin
        cnt_next_s = cnt_r;
        if (cnt_r == CNT_LAST) begin
            cnt_next_s = CNT_ZERO;
        end else begin
            cnt_next_s = cnt_r + CNT_W'(1);
        end
    end

    // Counter and look-ahead tick register; with DIV=1 the tick is always high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r  <= CNT_ZERO;
            tick_r <= (CNT_LAST == CNT_ZERO);
        end else begin
            cnt_r  <= cnt_next_s;
            tick_r <= (cnt_next_s == CNT_LAST);
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed digit scanner with frame-aligned double buffering and
// leading-zero blanking; nib feeds an external hex-to-7-segment decoder.
module seg_scan_mux
    import seg_scan_mux_pkg::*;
#(
    parameter int NDIG = NDIG_DEFAULT,
    parameter int DIV  = DIV_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [4*NDIG-1:0] value,
    input  logic              blank_lz,
    output logic [NDIG-1:0]   an,
    output logic [3:0]        nib,
    output logic              blank,
    output logic              pend,
    output logic              frame
);

    localparam int IDX_W = $clog2(NDIG);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NDIG - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO   = {IDX_W{1'b0}};
    localparam logic [NDIG-1:0]  AN_ALL_OFF = AN_IDLE[NDIG-1:0];
    localparam logic [NDIG-1:0]  AN_DIG0    = AN_ALL_OFF ^ NDIG'(1);
    localparam logic [4*NDIG-1:0] DISP_ZERO = {(4*NDIG){1'b0}};

    logic              tick_s;
    logic              frame_s;
    logic [IDX_W-1:0]  idx_r, idx_next_s;
    logic [4*NDIG-1:0] disp_r, disp_next_s;
    logic [4*NDIG-1:0] pbuf_r, pbuf_next_s;
    logic              pend_r, pend_next_s;
    logic [NDIG-1:0]   an_r, an_next_s;
    logic [3:0]        nib_r, nib_next_s;
    logic              blank_r, blank_next_s;

    // Digit di is dark when blanking is on and it and every higher nibble are zero.
    function automatic logic lz_blank(input logic [4*NDIG-1:0] d,
                                      input logic [IDX_W-1:0]  di,
                                      input logic              en);
        logic upper_zero;
        upper_zero = 1'b1;
        lz_blank   = 1'b0;
        for (int k = NDIG - 1; k >= 1; k--) begin
            upper_zero = upper_zero & (d[4*k +: 4] == 4'h0);
            lz_blank   = (IDX_W'(k) == di) ? (en & upper_zero) : lz_blank;
        end
    endfunction

    scan_prescaler #(.DIV(DIV)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (tick_s)
    );

    // Digit advance, frame-boundary commit and pending-buffer capture.
    always_comb begin
        frame_s     = 1'b0;
        idx_next_s  = idx_r;
        disp_next_s = disp_r;
        pbuf_next_s = pbuf_r;
        pend_next_s = pend_r;
        if (tick_s) begin
            if (idx_r == IDX_LAST) begin
                idx_next_s = IDX_ZERO;
                frame_s    = 1'b1;
            end else begin
                idx_next_s = idx_r + IDX_W'(1);
                frame_s    = 1'b0;
            end
        end else begin
            idx_next_s = idx_r;
            frame_s    = 1'b0;
        end
        // Commit uses the old pbuf; a coincident load refills it and keeps pend.
        if (frame_s && pend_r) begin
            disp_next_s = pbuf_r;
            pend_next_s = 1'b0;
        end else begin
            disp_next_s = disp_r;
            pend_next_s = pend_r;
        end
        if (load) begin
            pbuf_next_s = value;
            pend_next_s = 1'b1;
        end else begin
            pbuf_next_s = pbuf_r;
        end
    end

    // Display outputs derived from the next-state digit and display value.
    always_comb begin
        nib_next_s = 4'h0;
        for (int i = 0; i < NDIG; i++) begin
            nib_next_s = (idx_next_s == IDX_W'(i)) ? disp_next_s[4*i +: 4] : nib_next_s;
        end
        blank_next_s = lz_blank(disp_next_s, idx_next_s, blank_lz);
        if (blank_next_s) begin
            an_next_s = AN_ALL_OFF;
        end else begin
            an_next_s = ~(NDIG'(1) << idx_next_s);
        end
    end

    // State and output registers; outputs only move on a digit advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_r   <= IDX_ZERO;
            disp_r  <= DISP_ZERO;
            pbuf_r  <= DISP_ZERO;
            pend_r  <= 1'b0;
            an_r    <= AN_DIG0;
            nib_r   <= 4'h0;
            blank_r <= 1'b0;
        end else begin
            idx_r  <= idx_next_s;
            disp_r <= disp_next_s;
            pbuf_r <= pbuf_next_s;
            pend_r <= pend_next_s;
            if (tick_s) begin
                an_r    <= an_next_s;
                nib_r   <= nib_next_s;
                blank_r <= blank_next_s;
            end
        end
    end

    assign an    = an_r;
    assign nib   = nib_r;
    assign blank = blank_r;
    assign pend  = pend_r;
    assign frame = frame_s;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Self-checking bench for seg_scan_mux (NDIG=4, DIV=4): a cycle-count based
// reference model checked every cycle, a table of display vectors and corner sequences.
module tb_seg_scan_mux;

    localparam int NDIG  = 4;
    localparam int DIV   = 4;
    localparam int FRAME = NDIG * DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] value;
    logic        blank_lz;
    logic [3:0]  an;
    logic [3:0]  nib;
    logic        blank;
    logic        pend;
    logic        frame;

    seg_scan_mux #(.NDIG(NDIG), .DIV(DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .value    (value),
        .blank_lz (blank_lz),
        .an       (an),
        .nib      (nib),
        .blank    (blank),
        .pend     (pend),
        .frame    (frame)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          c;
    logic [15:0] mdisp;
    logic [15:0] mpbuf;
    logic        mpend;
    logic        mlz;

    typedef struct {
        logic [15:0] value;
        logic        blz;
        logic [15:0] e_an;     // digit i anodes in bits [4i+:4]
        logic [15:0] e_nib;
        logic [3:0]  e_blank;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, c, act, exp);
        end
    endtask

    // Expected outputs for cycle c follow from position in the frame.
    task automatic model_check();
        int         d;
        logic       bl;
        logic [3:0] e_an;
        d    = (c / DIV) % NDIG;
        bl   = (d != 0) && mlz && ((mdisp >> (4 * d)) == 16'h0000);
        e_an = bl ? 4'b1111 : ~(4'b0001 << d);
        chk("m_an",    32'(an),    32'(e_an));
        chk("m_nib",   32'(nib),   32'((mdisp >> (4 * d)) & 16'h000F));
        chk("m_blank", 32'(blank), 32'(bl));
        chk("m_pend",  32'(pend),  32'(mpend));
        chk("m_frame", 32'(frame), 32'((c % FRAME) == FRAME - 1));
    endtask

    task automatic step(input logic ld, input logic [15:0] val);
        model_check();
        load  = ld;
        value = val;
        @(posedge clk);
        if ((c % FRAME) == FRAME - 1 && mpend) begin
            mdisp = mpbuf;
            mpend = 1'b0;
        end
        if (ld) begin
            mpbuf = val;
            mpend = 1'b1;
        end
        if ((c % DIV) == DIV - 1) mlz = blank_lz;
        c++;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic to_frame_start();
        while ((c % FRAME) != 0) step(1'b0, 16'h0000);
    endtask

    task automatic finish_reset();
        @(posedge clk);
        @(negedge clk);
        rst   = 1'b0;
        c     = 0;
        mdisp = 16'h0000;
        mpbuf = 16'h0000;
        mpend = 1'b0;
        mlz   = 1'b0;
    endtask

    initial begin
        int first;
        rst = 1'b1; load = 1'b0; value = 16'h0000; blank_lz = 1'b0; c = 0;
        vecs[0] = '{16'h1234, 1'b0, 16'h7BDE, 16'h1234, 4'b0000};
        vecs[1] = '{16'h0050, 1'b1, 16'hFFDE, 16'h0050, 4'b1100};
        vecs[2] = '{16'h0000, 1'b1, 16'hFFFE, 16'h0000, 4'b1110};
        vecs[3] = '{16'h0050, 1'b0, 16'h7BDE, 16'h0050, 4'b0000};
        vecs[4] = '{16'h1000, 1'b1, 16'h7BDE, 16'h1000, 4'b0000};
        vecs[5] = '{16'h0A00, 1'b1, 16'hFBDE, 16'h0A00, 4'b1000};

        // Reset values, first frame pulse, load in cycle 2
        @(negedge clk);
        finish_reset();
        chk("rst_an",    32'(an),    32'(4'b1110));
        chk("rst_nib",   32'(nib),   32'(4'h0));
        chk("rst_blank", 32'(blank), 32'(1'b0));
        chk("rst_pend",  32'(pend),  32'(1'b0));
        chk("rst_frame", 32'(frame), 32'(1'b0));
        first = -1;
        while (c < FRAME) begin
            if (frame && first < 0) first = c;
            if (c == 3) chk("pend_rise", 32'(pend), 32'(1'b1));
            step(c == 2, 16'h1234);
        end
        chk("first_frame", 32'(first), 32'(15));
        chk("pend_clear", 32'(pend), 32'(1'b0));

        // Table of display vectors
        for (int i = 0; i < 6; i++) begin
            to_frame_start();
            blank_lz = vecs[i].blz;
            step(1'b1, vecs[i].value);
            to_frame_start();
            for (int k = 0; k < FRAME; k++) begin
                int d;
                d = k / DIV;
                chk($sformatf("vec%0d_an", i),    32'(an),    32'(vecs[i].e_an[4*d +: 4]));
                chk($sformatf("vec%0d_nib", i),   32'(nib),   32'(vecs[i].e_nib[4*d +: 4]));
                chk($sformatf("vec%0d_blank", i), 32'(blank), 32'(vecs[i].e_blank[d]));
                step(1'b0, 16'h0000);
            end
        end

        // Load collision on the frame boundary
        blank_lz = 1'b0;
        to_frame_start();
        step(1'b1, 16'hAAAA);
        while ((c % FRAME) != FRAME - 1) step(1'b0, 16'h0000);
        step(1'b1, 16'hBBBB);
        for (int k = 0; k < FRAME; k++) begin
            chk("coll_nib_a", 32'(nib),  32'(4'hA));
            chk("coll_pend",  32'(pend), 32'(1'b1));
            step(1'b0, 16'h0000);
        end
        for (int k = 0; k < FRAME; k++) begin
            chk("coll_nib_b", 32'(nib), 32'(4'hB));
            step(1'b0, 16'h0000);
        end

        // Overwrite within one frame: 1111 must never appear
        to_frame_start();
        step(1'b0, 16'h0000);
        step(1'b1, 16'h1111);
        repeat (3) step(1'b0, 16'h0000);
        step(1'b1, 16'h2222);
        while ((c % FRAME) != 0) begin
            chk("ovw_no1", 32'(nib == 4'h1), 32'(1'b0));
            step(1'b0, 16'h0000);
        end
        for (int k = 0; k < FRAME; k++) begin
            chk("ovw_nib2", 32'(nib), 32'(4'h2));
            step(1'b0, 16'h0000);
        end

        // Asynchronous reset while digit 2 is shown with a pending value
        to_frame_start();
        while ((c % FRAME) != 6) step(1'b0, 16'h0000);
        step(1'b1, 16'h9876);
        step(1'b0, 16'h0000);
        chk("mid_pend_pre", 32'(pend), 32'(1'b1));
        chk("mid_an_pre",   32'(an),   32'(4'b1011));
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_an",    32'(an),    32'(4'b1110));
        chk("mid_rst_nib",   32'(nib),   32'(4'h0));
        chk("mid_rst_blank", 32'(blank), 32'(1'b0));
        chk("mid_rst_pend",  32'(pend),  32'(1'b0));
        chk("mid_rst_frame", 32'(frame), 32'(1'b0));
        finish_reset();
        for (int k = 0; k < 2 * FRAME; k++) begin
            chk("mid_disp0", 32'(nib),  32'(4'h0));
            chk("mid_pend0", 32'(pend), 32'(1'b0));
            step(1'b0, 16'h0000);
        end

        // Randomized loads and blanking changes against the model
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 15) == 0) blank_lz = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0)
                step(1'b1, 16'($urandom) >> (4 * $urandom_range(0, 4)));
            else
                step(1'b0, 16'h0000);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
